// File: rtl/dc_mcl_scale_conf_responder_if.sv
// ---------------------------------------------------------------------------
// dc_mcl_scale_conf_responder_if
// Handshake and configuration bus between the cyclic dimension managers
// (master side) and the scale configuration responder (slave side).
//   conf_req              request valid (level), master -> slave
//   req_width/req_height  requested output dimensions
//   src_width/src_height  source dimensions
//   frame_start           one-cycle pulse at the start of an output frame
//   conf_ready            one-cycle pulse, configuration applied
//   busy                  responder is not idle
//   out_width/out_height  applied output dimensions
//   step_x/step_y         applied fixed-point scale steps (src/dst)
// ---------------------------------------------------------------------------
interface dc_mcl_scale_conf_responder_if #(
  parameter int SCR_SIZE_WIDTH = 12,
  parameter int FRAC_BITS      = 8
);
  localparam int Q = SCR_SIZE_WIDTH + FRAC_BITS;

  logic                      conf_req;
  logic [SCR_SIZE_WIDTH-1:0] req_width;
  logic [SCR_SIZE_WIDTH-1:0] req_height;
  logic [SCR_SIZE_WIDTH-1:0] src_width;
  logic [SCR_SIZE_WIDTH-1:0] src_height;
  logic                      frame_start;
  logic                      conf_ready;
  logic                      busy;
  logic [SCR_SIZE_WIDTH-1:0] out_width;
  logic [SCR_SIZE_WIDTH-1:0] out_height;
  logic [Q-1:0]              step_x;
  logic [Q-1:0]              step_y;

  modport master (
    output conf_req, req_width, req_height, src_width, src_height, frame_start,
    input  conf_ready, busy, out_width, out_height, step_x, step_y
  );

  modport slave (
    input  conf_req, req_width, req_height, src_width, src_height, frame_start,
    output conf_ready, busy, out_width, out_height, step_x, step_y
  );
endinterface

// File: rtl/dc_mcl_scale_conf_responder.sv
// ---------------------------------------------------------------------------
// dc_mcl_scale_conf_responder
// Accepts a requested output size, computes horizontal/vertical scale steps
// (src << FRAC_BITS) / req with a serial restoring divider (one quotient bit
// per cycle, MSB first), applies them to the output registers (optionally
// on a frame boundary) and pulses conf_ready.
// Ports:
//   clk   clock
//   nrst  asynchronous active-low reset
//   en    global enable, all registers hold while low
//   bus   slave side of dc_mcl_scale_conf_responder_if
// ---------------------------------------------------------------------------
module dc_mcl_scale_conf_responder #(
  parameter int SCR_SIZE_WIDTH = 12,
  parameter int FRAC_BITS      = 8,
  parameter int SYNC_TO_FRAME  = 1
) (
  input  logic clk,
  input  logic nrst,
  input  logic en,
  dc_mcl_scale_conf_responder_if.slave bus
);
  localparam int W     = SCR_SIZE_WIDTH;
  localparam int Q     = SCR_SIZE_WIDTH + FRAC_BITS;
  localparam int CNT_W = $clog2(Q);

  typedef enum logic [2:0] {IDLE, CALC_X, CALC_Y, WAIT_FRAME, APPLY, DONE} state_t;

  // One restoring-division step: returns {quotient bit, next remainder}.
  // The remainder stays below the divisor, so the shifted trial value always
  // fits in W+1 bits. A zero divisor yields a 1 every step, giving 2^Q-1.
  function automatic logic [W+1:0] div_step(input logic [W:0]   rem,
                                            input logic         din,
                                            input logic [W-1:0] dv);
    logic [W:0] trial;
    trial = {rem[W-1:0], din};
    if (dv == '0)
      div_step = {1'b1, trial};
    else if (trial >= {1'b0, dv})
      div_step = {1'b1, trial - {1'b0, dv}};
    else
      div_step = {1'b0, trial};
  endfunction

  state_t           r_state;
  logic [W-1:0]     r_req_w, r_req_h, r_src_h;
  logic [Q-1:0]     r_dvd;      // dividend, shifted out MSB first
  logic [W:0]       r_rem;
  logic [Q-1:0]     r_quo;      // quotient, shifted in LSB side
  logic [Q-1:0]     r_qx, r_qy;
  logic [CNT_W-1:0] r_cnt;
  logic             r_conf_ready, r_busy;
  logic [W-1:0]     r_out_width, r_out_height;
  logic [Q-1:0]     r_step_x, r_step_y;

  logic [W-1:0]     w_divisor;
  logic [W+1:0]     w_step;
  logic [W:0]       w_rem_next;
  logic [Q-1:0]     w_quo_next;
  logic             w_last;

  assign w_divisor  = (r_state == CALC_X) ? r_req_w : r_req_h;
  assign w_step     = div_step(r_rem, r_dvd[Q-1], w_divisor);
  assign w_rem_next = w_step[W:0];
  assign w_quo_next = {r_quo[Q-2:0], w_step[W+1]};
  assign w_last     = (r_cnt == CNT_W'(Q-1));

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state      <= IDLE;
      r_req_w      <= '0;
      r_req_h      <= '0;
      r_src_h      <= '0;
      r_dvd        <= '0;
      r_rem        <= '0;
      r_quo        <= '0;
      r_qx         <= '0;
      r_qy         <= '0;
      r_cnt        <= '0;
      r_conf_ready <= 1'b0;
      r_busy       <= 1'b0;
      r_out_width  <= '0;
      r_out_height <= '0;
      r_step_x     <= '0;
      r_step_y     <= '0;
    end else if (en) begin
      case (r_state)
        IDLE: begin
          if (bus.conf_req) begin
            // Source width only feeds the X dividend, so it is not kept.
            r_req_w <= bus.req_width;
            r_req_h <= bus.req_height;
            r_src_h <= bus.src_height;
            r_dvd   <= {bus.src_width, {FRAC_BITS{1'b0}}};
            r_rem   <= '0;
            r_quo   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= CALC_X;
          end
        end
        CALC_X: begin
          r_rem <= w_rem_next;
          r_quo <= w_quo_next;
          r_dvd <= r_dvd << 1;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_qx    <= w_quo_next;
            r_dvd   <= {r_src_h, {FRAC_BITS{1'b0}}};
            r_rem   <= '0;
            r_quo   <= '0;
            r_cnt   <= '0;
            r_state <= CALC_Y;
          end
        end
        CALC_Y: begin
          r_rem <= w_rem_next;
          r_quo <= w_quo_next;
          r_dvd <= r_dvd << 1;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_qy <= w_quo_next;
            if (SYNC_TO_FRAME != 0) begin
              r_state <= WAIT_FRAME;
            end else begin
              // Outputs and conf_ready are registered on entry to APPLY so
              // they become visible in the APPLY cycle itself.
              r_out_width  <= r_req_w;
              r_out_height <= r_req_h;
              r_step_x     <= r_qx;
              r_step_y     <= w_quo_next;
              r_conf_ready <= 1'b1;
              r_state      <= APPLY;
            end
          end
        end
        WAIT_FRAME: begin
          if (bus.frame_start) begin
            r_out_width  <= r_req_w;
            r_out_height <= r_req_h;
            r_step_x     <= r_qx;
            r_step_y     <= r_qy;
            r_conf_ready <= 1'b1;
            r_state      <= APPLY;
          end
        end
        APPLY: begin
          r_conf_ready <= 1'b0;
          r_state      <= DONE;
        end
        DONE: begin
          // Wait for the request to drop so a held request is not re-accepted.
          if (!bus.conf_req) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_conf_ready <= 1'b0;
          r_busy       <= 1'b0;
          r_state      <= IDLE;
        end
      endcase
    end
  end

  assign bus.conf_ready = r_conf_ready;
  assign bus.busy       = r_busy;
  assign bus.out_width  = r_out_width;
  assign bus.out_height = r_out_height;
  assign bus.step_x     = r_step_x;
  assign bus.step_y     = r_step_y;

endmodule

// File: tb/tb_dc_mcl_scale_conf_responder.sv
// ---------------------------------------------------------------------------
// tb_dc_mcl_scale_conf_responder
// Directed bench: u0 applies immediately, u1 waits for frame_start.
// Cycle k is the k-th clock period after the accepting edge; inputs are
// driven and outputs sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_dc_mcl_scale_conf_responder;
  logic clk;
  logic nrst;
  logic en;
  int   n_cmp;
  int   n_fail;

  dc_mcl_scale_conf_responder_if #(.SCR_SIZE_WIDTH(12), .FRAC_BITS(8)) b0 ();
  dc_mcl_scale_conf_responder_if #(.SCR_SIZE_WIDTH(12), .FRAC_BITS(8)) b1 ();

  dc_mcl_scale_conf_responder #(.SCR_SIZE_WIDTH(12), .FRAC_BITS(8), .SYNC_TO_FRAME(0)) u0 (
    .clk(clk), .nrst(nrst), .en(en), .bus(b0));
  dc_mcl_scale_conf_responder #(.SCR_SIZE_WIDTH(12), .FRAC_BITS(8), .SYNC_TO_FRAME(1)) u1 (
    .clk(clk), .nrst(nrst), .en(en), .bus(b1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Starts a request on u0 at the current falling edge and runs ncyc cycles,
  // recording conf_ready pulses. en is dropped at cycle en_off and restored
  // at cycle en_on (pass -1 to leave it alone). conf_req stays high.
  task automatic run_u0(input logic [11:0] sw, input logic [11:0] sh,
                        input logic [11:0] rw, input logic [11:0] rh,
                        input int en_off, input int en_on, input int ncyc,
                        output int first, output int npulse);
    b0.src_width  = sw;
    b0.src_height = sh;
    b0.req_width  = rw;
    b0.req_height = rh;
    b0.conf_req   = 1'b1;
    first  = -1;
    npulse = 0;
    for (int k = 1; k <= ncyc; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (b0.conf_ready === 1'b1) begin
        npulse++;
        if (first < 0) first = k;
      end
      if (k == en_off) en = 1'b0;
      if (k == en_on)  en = 1'b1;
    end
  endtask

  task automatic release_u0();
    b0.conf_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    en   = 1'b1;
    b0.conf_req = 1'b0; b0.frame_start = 1'b0;
    b0.src_width = '0; b0.src_height = '0; b0.req_width = '0; b0.req_height = '0;
    b1.conf_req = 1'b0; b1.frame_start = 1'b0;
    b1.src_width = '0; b1.src_height = '0; b1.req_width = '0; b1.req_height = '0;
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({b0.conf_ready, b0.busy, b0.out_width, b0.out_height, b0.step_x, b0.step_y} !== '0) begin
      n_fail++;
      $display("FAIL reset_u0: got rdy=%b busy=%b w=%0d h=%0d sx=%h sy=%h, expected all 0",
               b0.conf_ready, b0.busy, b0.out_width, b0.out_height, b0.step_x, b0.step_y);
    end
    n_cmp++;
    if ({b1.conf_ready, b1.busy, b1.out_width, b1.out_height, b1.step_x, b1.step_y} !== '0) begin
      n_fail++;
      $display("FAIL reset_u1: got rdy=%b busy=%b sx=%h, expected all 0",
               b1.conf_ready, b1.busy, b1.step_x);
    end
  endtask

  task automatic test_basic();
    int first, np;
    run_u0(12'd640, 12'd480, 12'd320, 12'd240, -1, -1, 60, first, np);
    n_cmp++;
    if (first !== 41) begin n_fail++; $display("FAIL basic_latency: got %0d expected 41", first); end
    n_cmp++;
    if (np !== 1) begin n_fail++; $display("FAIL basic_single_pulse: got %0d pulses expected 1", np); end
    n_cmp++;
    if (b0.step_x !== 20'h00200 || b0.step_y !== 20'h00200) begin
      n_fail++;
      $display("FAIL basic_steps: got %h/%h expected 00200/00200", b0.step_x, b0.step_y);
    end
    n_cmp++;
    if (b0.out_width !== 12'd320 || b0.out_height !== 12'd240) begin
      n_fail++;
      $display("FAIL basic_dims: got %0dx%0d expected 320x240", b0.out_width, b0.out_height);
    end
    n_cmp++;
    if (b0.busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_done: got %b expected 1", b0.busy); end
    release_u0();
    n_cmp++;
    if (b0.busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle: got busy=%b expected 0", b0.busy); end
  endtask

  task automatic test_back_to_back();
    int first, np;
    run_u0(12'd640, 12'd480, 12'd1280, 12'd960, -1, -1, 45, first, np);
    n_cmp++;
    if (first !== 41 || b0.step_x !== 20'h00080 || b0.step_y !== 20'h00080) begin
      n_fail++;
      $display("FAIL upscale: got cyc=%0d sx=%h sy=%h expected 41/00080/00080", first, b0.step_x, b0.step_y);
    end
    release_u0();
    run_u0(12'd640, 12'd480, 12'd640, 12'd480, -1, -1, 45, first, np);
    n_cmp++;
    if (first !== 41 || b0.step_x !== 20'h00100 || b0.step_y !== 20'h00100) begin
      n_fail++;
      $display("FAIL rerequest: got cyc=%0d sx=%h sy=%h expected 41/00100/00100", first, b0.step_x, b0.step_y);
    end
    release_u0();
  endtask

  task automatic test_div_zero();
    int first, np;
    run_u0(12'd640, 12'd480, 12'd0, 12'd240, -1, -1, 45, first, np);
    n_cmp++;
    if (first !== 41) begin n_fail++; $display("FAIL divzero_latency: got %0d expected 41", first); end
    n_cmp++;
    if (b0.step_x !== 20'hFFFFF || b0.step_y !== 20'h00200) begin
      n_fail++;
      $display("FAIL divzero_steps: got %h/%h expected FFFFF/00200", b0.step_x, b0.step_y);
    end
    release_u0();
  endtask

  task automatic test_frame_sync();
    int first, np;
    logic [19:0] sx_at100;
    b1.src_width = 12'd640; b1.src_height = 12'd480;
    b1.req_width = 12'd320; b1.req_height = 12'd240;
    b1.conf_req = 1'b1;
    first = -1; np = 0; sx_at100 = 20'h12345;
    for (int k = 1; k <= 110; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (b1.conf_ready === 1'b1) begin
        np++;
        if (first < 0) first = k;
      end
      if (k == 100) sx_at100 = b1.step_x;
      b1.frame_start = (k == 10 || k == 100);
    end
    n_cmp++;
    if (sx_at100 !== 20'h00000) begin n_fail++; $display("FAIL sync_hold: got %h at cycle 100 expected 00000", sx_at100); end
    n_cmp++;
    if (first !== 101 || np !== 1) begin
      n_fail++;
      $display("FAIL sync_ready: got cyc=%0d pulses=%0d expected 101/1", first, np);
    end
    n_cmp++;
    if (b1.step_x !== 20'h00200 || b1.out_height !== 12'd240) begin
      n_fail++;
      $display("FAIL sync_apply: got sx=%h h=%0d expected 00200/240", b1.step_x, b1.out_height);
    end
    b1.conf_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    int first, np;
    run_u0(12'd640, 12'd480, 12'd320, 12'd240, -1, -1, 20, first, np);
    n_cmp++;
    if (b0.busy !== 1'b1 || b0.step_x !== 20'hFFFFF) begin
      n_fail++;
      $display("FAIL prereset_state: got busy=%b sx=%h expected 1/FFFFF", b0.busy, b0.step_x);
    end
    nrst = 1'b0;
    #1;
    n_cmp++;
    if ({b0.busy, b0.conf_ready, b0.out_height, b0.step_x, b0.step_y} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got busy=%b h=%0d sx=%h sy=%h expected all 0",
               b0.busy, b0.out_height, b0.step_x, b0.step_y);
    end
    b0.conf_req = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    run_u0(12'd640, 12'd480, 12'd320, 12'd240, -1, -1, 45, first, np);
    n_cmp++;
    if (first !== 41 || b0.step_x !== 20'h00200) begin
      n_fail++;
      $display("FAIL post_reset: got cyc=%0d sx=%h expected 41/00200", first, b0.step_x);
    end
    release_u0();
  endtask

  task automatic test_enable();
    int first, np;
    run_u0(12'd640, 12'd480, 12'd160, 12'd120, 25, 30, 60, first, np);
    n_cmp++;
    if (first !== 46 || np !== 1) begin
      n_fail++;
      $display("FAIL en_stall: got cyc=%0d pulses=%0d expected 46/1", first, np);
    end
    n_cmp++;
    if (b0.step_x !== 20'h00400 || b0.step_y !== 20'h00400) begin
      n_fail++;
      $display("FAIL en_steps: got %h/%h expected 00400/00400", b0.step_x, b0.step_y);
    end
    release_u0();
    // Freeze a conf_ready that is currently high.
    run_u0(12'd640, 12'd480, 12'd320, 12'd240, 41, -1, 41, first, np);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (b0.conf_ready !== 1'b1) begin n_fail++; $display("FAIL en_freeze_ready: got %b expected 1", b0.conf_ready); end
    en = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (b0.conf_ready !== 1'b0) begin n_fail++; $display("FAIL en_resume_ready: got %b expected 0", b0.conf_ready); end
    release_u0();
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_div_zero();
    test_frame_sync();
    test_async_reset();
    test_enable();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/dc_mcl_scale_conf_responder.md
Name: dc_mcl_scale_conf_responder

Overview:
- Configuration-side responder to the cyclic dimension managers in main control logic.
- Accepts a requested output width/height over a req/ready handshake and computes fixed-point horizontal/vertical scale steps (src/dst) with a serial restoring divider.
- Applies the result to its output registers, optionally on a frame boundary, then pulses conf_ready to close the handshake.
- Consumers of the output registers are the layer-0 scaler datapath.

Parameters:
- SCR_SIZE_WIDTH, 12, width of all dimension buses.
- FRAC_BITS, 8, fractional bits of the scale steps; Q = SCR_SIZE_WIDTH+FRAC_BITS.
- SYNC_TO_FRAME, 1, 1: apply only on frame_start; 0: apply immediately after computation.

Ports:
- clk  in  1  clock.
- nrst  in  1  reset, asynchronous, active-low.
- en  in  1  global enable; when low, every register holds its value.
- conf_req  in  1  request valid (level) from the managers.
- req_width  in  SCR_SIZE_WIDTH  requested output width.
- req_height  in  SCR_SIZE_WIDTH  requested output height.
- src_width  in  SCR_SIZE_WIDTH  source width.
- src_height  in  SCR_SIZE_WIDTH  source height.
- frame_start  in  1  single-cycle pulse at start of output frame.
- conf_ready  out  1  single-cycle pulse: configuration applied.
- busy  out  1  high in any state other than IDLE.
- out_width  out  SCR_SIZE_WIDTH  applied output width.
- out_height  out  SCR_SIZE_WIDTH  applied output height.
- step_x  out  Q  applied horizontal step, (src_width<<FRAC_BITS)/req_width.
- step_y  out  Q  applied vertical step, (src_height<<FRAC_BITS)/req_height.

Behaviour:
- Reset values: state IDLE; conf_ready 0; busy 0; out_width/out_height 0; step_x/step_y 0; divider registers 0.
- All register updates are qualified by en. With en low, the FSM, counters and outputs freeze, including a conf_ready that is currently high.
- FSM states: IDLE, CALC_X, CALC_Y, WAIT_FRAME, APPLY, DONE.
- IDLE: when conf_req is 1, latch req_width, req_height, src_width and src_height into shadow registers, then go to CALC_X. Inputs are never re-sampled until the next acceptance.
- CALC_X / CALC_Y: restoring division, one quotient bit per cycle, MSB first. A counter runs Q cycles per axis.
  - Dividend = src<<FRAC_BITS, Q bits. Remainder register is SCR_SIZE_WIDTH+1 bits.
  - The quotient always fits in Q bits, so there is no overflow.
- Divisor 0: the quotient is forced to all-ones (2^Q-1) for that axis. The axis still takes Q cycles, so latency is unchanged.
- After CALC_Y:
  - SYNC_TO_FRAME=1: go to WAIT_FRAME.
  - SYNC_TO_FRAME=0: go to APPLY.
- WAIT_FRAME: go to APPLY on the cycle after frame_start is seen high. A frame_start during IDLE, CALC_X or CALC_Y is ignored (not remembered).
- APPLY: one cycle. Output registers load the shadow dims and quotients; conf_ready is 1 in this same cycle. Then go to DONE.
- DONE: wait for conf_req == 0, then go to IDLE. A conf_req held high across conf_ready is never accepted twice.
- Latency, SYNC_TO_FRAME=0, acceptance edge = cycle 0: conf_ready is high in cycle 2Q+1.
- Latency, SYNC_TO_FRAME=1: conf_ready is high 1 cycle after the first frame_start that is sampled in WAIT_FRAME.
- conf_req dropping mid-operation does not abort; the computation completes and conf_ready still pulses.
- Request values changing mid-operation are ignored.
- Asynchronous reset mid-operation returns everything to reset values immediately. Applied outputs revert to 0.

Test Plan:
1. W=12, FRAC=8, SYNC=0; src 640x480, req 320x240, conf_req held high -> conf_ready is one pulse at cycle 41; step_x=0x00200, step_y=0x00200; out 320x240; no second pulse while conf_req stays high.
2. src 640x480, req 1280x960 -> step_x=0x00080, step_y=0x00080. Then drop conf_req for 1 cycle and re-request 640x480 -> step_x=0x00100 after a further 41 cycles.
3. req_width=0, req_height=240, src 640x480 -> step_x=0xFFFFF, step_y=0x00200, conf_ready still at cycle 41.
4. SYNC=1; frame_start at cycle 10 (during CALC_X), then at cycle 100 -> outputs unchanged until cycle 101; conf_ready high only at cycle 101.
5. Assert nrst low at cycle 20 of CALC_X -> all outputs 0 and busy 0 immediately. A new request after release completes normally with the 41-cycle latency.
6. en low for 5 cycles during CALC_Y -> conf_ready is delayed by exactly 5 cycles (cycle 46) and step values are unaltered.
